fxp32_dot_ctrl: RTL and testbench
=================================

# fxp32_dot_ctrl

Sequencer that computes a fixed-point dot product on one shared `fxp32_mac` instance. On `start` it clears the MAC accumulator and streams `len` operand pairs from two synchronous-read operand memories into the MAC. It waits for the MAC pipeline to drain, then captures `out_c` and presents it through a valid/ready result port. It sits between the command/register front-end and the MAC datapath, and owns the MAC's `acc`, `prstn`, `in_a` and `in_b` pins.

## Interface
Parameters:
- `ADDR_W`, 10: operand memory address width.
- `LEN_W`, 11: width of the element-count field.
- `MAC_LAT`, 1: number of clock edges from an `acc=1` edge until the product is visible on `mac_out_c`.

Ports (clock and reset first):
- `clk` in 1: single clock for the whole block, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: command strobe; sampled only in IDLE.
- `len` in LEN_W: element count, latched on start.
- `a_base` in ADDR_W: vector A start address, latched on start.
- `b_base` in ADDR_W: vector B start address, latched on start.
- `busy` out 1: high in every state except IDLE.
- `rd_en` out 1: read strobe to both operand memories.
- `a_addr` out ADDR_W: vector A read address.
- `b_addr` out ADDR_W: vector B read address.
- `a_rdata` in 32: vector A read data, valid one cycle after `rd_en`.
- `b_rdata` in 32: vector B read data, valid one cycle after `rd_en`.
- `mac_prstn` out 1: MAC accumulator clear, active-low.
- `mac_acc` out 1: MAC accumulate enable.
- `mac_in_a` out 32: MAC operand A.
- `mac_in_b` out 32: MAC operand B.
- `mac_out_c` in 32: MAC accumulator output.
- `res` out 32: captured dot-product result.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer ready.

## Operation
- The FSM has five states: IDLE, CLEAR, RUN, DRAIN and DONE.
- IDLE: if `start`=1, latch `len`, `a_base`, `b_base` and move to CLEAR.
- CLEAR: lasts one cycle with `mac_prstn`=0. Moves to RUN if the latched len≠0, otherwise straight to DRAIN.
- RUN: lasts len cycles.
  - Cycle k (k=0..len-1) asserts `rd_en` with `a_addr`=a_base+k·stride and `b_addr`=b_base+k·stride.
  - Addresses wrap modulo 2^ADDR_W.
  - After the last issue, the FSM moves to DRAIN.
- Read pipeline: `rd_en` is delayed by one register to form `mac_acc`. `mac_in_a`/`mac_in_b` are driven combinationally from `a_rdata`/`b_rdata`. Each pair is therefore accumulated exactly once, in order.
- DRAIN: lasts MAC_LAT+1 cycles, counted by a down-counter. On its final edge, `mac_out_c` is captured into `res` and the FSM moves to DONE.
- DONE: `res_valid`=1. When `res_valid`&`res_ready`, the FSM returns to IDLE on the next cycle. `res` holds until the next capture.
- `start` is ignored in every state except IDLE, including the cycle of the result handshake.
- The block does no arithmetic on data. Width, rounding and overflow are governed entirely by `fxp32_mac` (Q16.16).

## Timing
- Take cycle 0 as the cycle in which `start` is sampled in IDLE:
  - CLEAR is cycle 1.
  - RUN issues in cycles 2..len+1.
  - `mac_acc` is high in cycles 3..len+2.
  - DRAIN occupies cycles len+2..len+MAC_LAT+2.
  - `res_valid` first rises in cycle len+MAC_LAT+3. This holds for len=0 as well.
- `busy` rises in cycle 1 and falls in the cycle after the result handshake.
- Reset values: `busy`=0, `rd_en`=0, addresses=0, `mac_acc`=0, `mac_prstn`=0 (MAC held clear), `res`=0, `res_valid`=0, FSM=IDLE.
- `mac_prstn` returns to 1 on the first edge after reset release.
- Reset asserted mid-operation: immediate return to reset values. Any pending result is discarded, and no `mac_acc` pulse leaks out after reset.
- `res_ready` held low: the block stays in DONE indefinitely with `res` stable.

## Configuration
- `FXP32_DOT_CTRL_STRIDE_EN` defined: adds input ports `a_stride` and `b_stride` (ADDR_W each), latched on start. Addresses advance by the respective stride each RUN cycle, with wrap-around.
- Macro undefined: the stride ports do not exist and stride is fixed at 1.

## Test plan
- A[0..2]=0x00010000, B[0..2]=0x00020000, len=3, bases 0 → `res`=0x00060000; `res_valid` rises in cycle 3+MAC_LAT+3; exactly 3 `mac_acc` pulses.
- len=0 → one `mac_prstn` pulse, no `rd_en`, `res`=0x00000000, `res_valid` rises in cycle MAC_LAT+3.
- Hold `res_ready`=0 for 10 cycles, with `start` pulsed in DONE → `res` stable, `start` ignored; after the handshake the FSM reaches IDLE and a new start is accepted.
- a_base=2^ADDR_W−2, len=4 → `a_addr` sequence is 0x3FE, 0x3FF, 0x000, 0x001.
- Assert `rst` mid-RUN of a len=8 command → all outputs take reset values immediately. A following len=1 run with A=0x00030000, B=0x00010000 gives `res`=0x00030000, with no residue from the aborted run.
- With the stride macro defined: a_stride=2, b_stride=3, len=3, bases 0 → `a_addr` sequence is 0,2,4 and `b_addr` sequence is 0,3,6.

Source files
------------

// File: rtl/fxp32_dot_ctrl.sv
// fxp32_dot_ctrl
// Dot-product sequencer for a shared fxp32_mac instance. On a start command it
// clears the MAC, streams len operand pairs out of two synchronous-read operand
// memories into the MAC, waits for the MAC pipeline to drain, and then holds
// the captured accumulator value on a valid/ready result port.
//
// Optional build feature: define FXP32_DOT_CTRL_STRIDE_EN to add per-vector
// address strides (a_stride, b_stride). Without it both strides are fixed at 1.
//
// No arithmetic is done on data here; Q16.16 width, rounding and overflow
// behaviour belong entirely to fxp32_mac.

module fxp32_dot_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int LEN_W   = 11,
   parameter int MAC_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
`ifdef FXP32_DOT_CTRL_STRIDE_EN
   input  logic [ADDR_W-1:0] a_stride,
   input  logic [ADDR_W-1:0] b_stride,
`endif
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   input  logic [31:0]       a_rdata,
   input  logic [31:0]       b_rdata,
   output logic              mac_prstn,
   output logic              mac_acc,
   output logic [31:0]       mac_in_a,
   output logic [31:0]       mac_in_b,
   input  logic [31:0]       mac_out_c,
   output logic [31:0]       res,
   output logic              res_valid,
   input  logic              res_ready
);

   // Drain counter must hold MAC_LAT; the extra bit keeps MAC_LAT=0 legal.
   localparam int DRN_W = $clog2(MAC_LAT + 1) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              r_state;

   // Command fields captured on start
   logic [LEN_W-1:0]    r_len;
   logic [ADDR_W-1:0]   r_a_base;
   logic [ADDR_W-1:0]   r_b_base;

   // Remaining issues in RUN minus one, and remaining drain edges
   logic [LEN_W-1:0]    r_cnt;
   logic [DRN_W-1:0]    r_drn;

   // Registered outputs
   logic                r_busy;
   logic                r_rd_en_p0;
   logic [ADDR_W-1:0]   r_a_addr;
   logic [ADDR_W-1:0]   r_b_addr;
   logic                r_prstn;
   logic [31:0]         r_res;
   logic                r_res_valid;

   // Read-data stage: memories return data one cycle after rd_en
   logic                r_acc_p1;

   logic [ADDR_W-1:0]   w_a_stride;
   logic [ADDR_W-1:0]   w_b_stride;

`ifdef FXP32_DOT_CTRL_STRIDE_EN
   logic [ADDR_W-1:0]   r_a_stride;
   logic [ADDR_W-1:0]   r_b_stride;

   // Latch the per-vector strides alongside the rest of the command
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_stride <= '0;
         r_b_stride <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_a_stride <= a_stride;
         r_b_stride <= b_stride;
      end
   end

   assign w_a_stride = r_a_stride;
   assign w_b_stride = r_b_stride;
`else
   assign w_a_stride = ADDR_W'(1);
   assign w_b_stride = ADDR_W'(1);
`endif

   // Command sequencer: all control outputs are registered here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_a_base    <= '0;
         r_b_base    <= '0;
         r_cnt       <= '0;
         r_drn       <= '0;
         r_busy      <= 1'b0;
         r_rd_en_p0  <= 1'b0;
         r_a_addr    <= '0;
         r_b_addr    <= '0;
         r_prstn     <= 1'b0;
         r_res       <= '0;
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // The MAC is released from its reset-time clear here.
               r_prstn <= 1'b1;
               if (start) begin
                  r_len    <= len;
                  r_a_base <= a_base;
                  r_b_base <= b_base;
                  r_busy   <= 1'b1;
                  r_prstn  <= 1'b0;
                  r_state  <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               r_prstn <= 1'b1;
               if (r_len != '0) begin
                  r_rd_en_p0 <= 1'b1;
                  r_a_addr   <= r_a_base;
                  r_b_addr   <= r_b_base;
                  r_cnt      <= r_len - LEN_W'(1);
                  r_state    <= S_RUN;
               end else begin
                  // Empty vector: nothing to read, just let the cleared MAC settle.
                  r_drn   <= DRN_W'(MAC_LAT);
                  r_state <= S_DRAIN;
               end
            end

            S_RUN: begin
               if (r_cnt == '0) begin
                  r_rd_en_p0 <= 1'b0;
                  r_drn      <= DRN_W'(MAC_LAT);
                  r_state    <= S_DRAIN;
               end else begin
                  // Address arithmetic wraps naturally at ADDR_W bits.
                  r_a_addr <= r_a_addr + w_a_stride;
                  r_b_addr <= r_b_addr + w_b_stride;
                  r_cnt    <= r_cnt - LEN_W'(1);
               end
            end

            S_DRAIN: begin
               // One cycle for the read-data stage plus MAC_LAT for the MAC itself.
               if (r_drn == '0) begin
                  r_res       <= mac_out_c;
                  r_res_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_drn <= r_drn - DRN_W'(1);
               end
            end

            S_DONE: begin
               // start is deliberately not looked at here, even on the handshake cycle.
               if (r_res_valid && res_ready) begin
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Align the accumulate strobe with the memory read data it qualifies
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc_p1 <= 1'b0;
      end else begin
         r_acc_p1 <= r_rd_en_p0;
      end
   end

   assign busy      = r_busy;
   assign rd_en     = r_rd_en_p0;
   assign a_addr    = r_a_addr;
   assign b_addr    = r_b_addr;
   assign mac_prstn = r_prstn;
   assign mac_acc   = r_acc_p1;
   assign mac_in_a  = a_rdata;
   assign mac_in_b  = b_rdata;
   assign res       = r_res;
   assign res_valid = r_res_valid;

endmodule

// File: tb/tb_fxp32_dot_ctrl.sv
// Directed testbench for fxp32_dot_ctrl with a behavioural pair of operand
// memories and a Q16.16 MAC (latency 1) hanging off the DUT.

module tb_fxp32_dot_ctrl;

   localparam int ADDR_W  = 10;
   localparam int LEN_W   = 11;
   localparam int MAC_LAT = 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic [ADDR_W-1:0] a_base = '0;
   logic [ADDR_W-1:0] b_base = '0;
`ifdef FXP32_DOT_CTRL_STRIDE_EN
   logic [ADDR_W-1:0] a_stride = ADDR_W'(1);
   logic [ADDR_W-1:0] b_stride = ADDR_W'(1);
`endif
   logic              busy;
   logic              rd_en;
   logic [ADDR_W-1:0] a_addr;
   logic [ADDR_W-1:0] b_addr;
   logic [31:0]       a_rdata = '0;
   logic [31:0]       b_rdata = '0;
   logic              mac_prstn;
   logic              mac_acc;
   logic [31:0]       mac_in_a;
   logic [31:0]       mac_in_b;
   logic [31:0]       mac_out_c = '0;
   logic [31:0]       res;
   logic              res_valid;
   logic              res_ready = 1'b1;

   fxp32_dot_ctrl #(
      .ADDR_W  (ADDR_W),
      .LEN_W   (LEN_W),
      .MAC_LAT (MAC_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .a_base    (a_base),
      .b_base    (b_base),
`ifdef FXP32_DOT_CTRL_STRIDE_EN
      .a_stride  (a_stride),
      .b_stride  (b_stride),
`endif
      .busy      (busy),
      .rd_en     (rd_en),
      .a_addr    (a_addr),
      .b_addr    (b_addr),
      .a_rdata   (a_rdata),
      .b_rdata   (b_rdata),
      .mac_prstn (mac_prstn),
      .mac_acc   (mac_acc),
      .mac_in_a  (mac_in_a),
      .mac_in_b  (mac_in_b),
      .mac_out_c (mac_out_c),
      .res       (res),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read operand memories
   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];
   always @(posedge clk) begin
      if (rd_en) begin
         a_rdata <= mem_a[a_addr];
         b_rdata <= mem_b[b_addr];
      end
   end

   // Q16.16 MAC, one edge from acc to visible output
   logic signed [63:0] w_prod;
   assign w_prod = $signed(mac_in_a) * $signed(mac_in_b);
   always @(posedge clk) begin
      if (!mac_prstn)   mac_out_c <= '0;
      else if (mac_acc) mac_out_c <= mac_out_c + w_prod[47:16];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Per-command observations
   int                t_vld;
   int                n_acc;
   int                n_rd;
   int                n_clr;
   logic              busy_c1;
   logic [31:0]       res_cap;
   logic [ADDR_W-1:0] a_seq [$];
   logic [ADDR_W-1:0] b_seq [$];

   // Issue a command in cycle 0 and observe until res_valid first rises.
   task automatic issue(input int n, input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] bb);
      int c0;
      @(negedge clk);
      start  = 1'b1;
      len    = LEN_W'(n);
      a_base = ab;
      b_base = bb;
      c0     = cyc;
      a_seq.delete();
      b_seq.delete();
      n_acc = 0; n_rd = 0; n_clr = 0; t_vld = -1; busy_c1 = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i < 200; i++) begin
         @(negedge clk);
         if (i == 1) busy_c1 = busy;
         if (!mac_prstn) n_clr++;
         if (mac_acc) n_acc++;
         if (rd_en) begin
            n_rd++;
            a_seq.push_back(a_addr);
            b_seq.push_back(b_addr);
         end
         if (res_valid) begin
            t_vld   = cyc - c0;
            res_cap = res;
            break;
         end
      end
      if (t_vld < 0) check("timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bad;
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      for (int i = 0; i < 3; i++) begin
         mem_a[i] = 32'h0001_0000;
         mem_b[i] = 32'h0002_0000;
      end
      mem_a[10]  = 32'h0000_8000;  // 0.5
      mem_b[10]  = 32'h0004_0000;  // 4.0
      mem_a[11]  = 32'hFFFF_0000;  // -1.0
      mem_b[11]  = 32'h0001_0000;  // 1.0
      mem_a[100] = 32'h0003_0000;
      mem_b[100] = 32'h0001_0000;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_busy",  busy,      1'b0);
      check("rst_rd_en", rd_en,     1'b0);
      check("rst_a_addr", a_addr,   '0);
      check("rst_b_addr", b_addr,   '0);
      check("rst_acc",   mac_acc,   1'b0);
      check("rst_prstn", mac_prstn, 1'b0);
      check("rst_res",   res,       32'h0);
      check("rst_vld",   res_valid, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("prstn_release", mac_prstn, 1'b1);

      // Basic dot product: 3 x (1.0 * 2.0) = 6.0
      issue(3, 10'd0, 10'd0);
      check("dot3_res",   res_cap, 32'h0006_0000);
      check("dot3_tvld",  t_vld,   32'd7);
      check("dot3_acc",   n_acc,   32'd3);
      check("dot3_rd",    n_rd,    32'd3);
      check("dot3_clr",   n_clr,   32'd1);
      check("dot3_busy1", busy_c1, 1'b1);
      @(negedge clk);
      check("dot3_idle",  busy,    1'b0);

      // Empty vector
      issue(0, 10'd0, 10'd0);
      check("len0_res",  res_cap, 32'h0);
      check("len0_tvld", t_vld,   32'd4);
      check("len0_rd",   n_rd,    32'd0);
      check("len0_acc",  n_acc,   32'd0);
      check("len0_clr",  n_clr,   32'd1);
      @(negedge clk);

      // Back-pressure: 0.5*4.0 + (-1.0)*1.0 = 1.0, held with res_ready low
      res_ready = 1'b0;
      issue(2, 10'd10, 10'd10);
      check("hold_res0", res_cap, 32'h0001_0000);
      check("hold_tvld", t_vld,   32'd6);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin start = 1'b1; len = LEN_W'(5); end
         if (i == 4) start = 1'b0;
         @(negedge clk);
         if (res !== 32'h0001_0000 || res_valid !== 1'b1 || busy !== 1'b1 || rd_en !== 1'b0) bad++;
      end
      check("hold_stable", bad, 32'd0);
      // Handshake with start asserted in the same cycle: start must be ignored
      res_ready = 1'b1;
      start = 1'b1; len = LEN_W'(3); a_base = '0; b_base = '0;
      @(negedge clk);
      check("hs_busy", busy,      1'b0);
      check("hs_vld",  res_valid, 1'b0);
      start = 1'b0;
      issue(3, 10'd0, 10'd0);
      check("after_hold_res", res_cap, 32'h0006_0000);
      @(negedge clk);

      // Address wrap-around
      issue(4, 10'h3FE, 10'd0);
      check("wrap_rd", n_rd, 32'd4);
      if (a_seq.size() == 4) begin
         check("wrap_a0", a_seq[0], 10'h3FE);
         check("wrap_a1", a_seq[1], 10'h3FF);
         check("wrap_a2", a_seq[2], 10'h000);
         check("wrap_a3", a_seq[3], 10'h001);
      end
      @(negedge clk);

      // Reset in the middle of RUN
      @(negedge clk);
      start = 1'b1; len = LEN_W'(8); a_base = '0; b_base = '0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_in_run", rd_en, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("abort_busy",  busy,      1'b0);
      check("abort_rd_en", rd_en,     1'b0);
      check("abort_addr",  a_addr,    '0);
      check("abort_acc",   mac_acc,   1'b0);
      check("abort_prstn", mac_prstn, 1'b0);
      check("abort_res",   res,       32'h0);
      check("abort_vld",   res_valid, 1'b0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (mac_acc !== 1'b0) bad++;
      end
      check("abort_no_acc", bad, 32'd0);
      rst = 1'b0;
      issue(1, 10'd100, 10'd100);
      check("post_abort_res", res_cap, 32'h0003_0000);
      check("post_abort_acc", n_acc,   32'd1);

`ifdef FXP32_DOT_CTRL_STRIDE_EN
      @(negedge clk);
      a_stride = ADDR_W'(2);
      b_stride = ADDR_W'(3);
      issue(3, 10'd0, 10'd0);
      check("stride_rd", n_rd, 32'd3);
      if (a_seq.size() == 3 && b_seq.size() == 3) begin
         check("stride_a1", a_seq[1], 10'd2);
         check("stride_a2", a_seq[2], 10'd4);
         check("stride_b1", b_seq[1], 10'd3);
         check("stride_b2", b_seq[2], 10'd6);
      end
`endif

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
